// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the round-robin display scheduler and its
// sequential binary-to-BCD converter.
package display_scheduler_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned VAL_W   = 14;
    localparam int unsigned DIG_W   = 4;
    localparam int unsigned NUM_DIG = 4;
    localparam int unsigned BCD_W   = NUM_DIG * DIG_W;
    localparam int unsigned EN_W    = 8;

    localparam logic [DIG_W-1:0] BLANK_CODE  = 4'hF;
    localparam logic [VAL_W-1:0] MAX_DISPLAY = 14'd9999;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // Replace zero digits above the most significant nonzero digit with blanks;
    // digit 0 is never blanked so a value of 0 still shows "0".
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        logic             seen;
        res  = bcd;
        seen = 1'b0;
        for (int i = int'(NUM_DIG) - 1; i >= 1; i--) begin
            if (bcd[i*DIG_W +: DIG_W] != 4'd0) begin
                seen = 1'b1;
            end
            if (!seen) begin
                res[i*DIG_W +: DIG_W] = BLANK_CODE;
            end
        end
        return res;
    endfunction

    // Round-robin choice: first asserted request at or after last+1 (mod NUM_REQ).
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        logic            found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            idx = last + ID_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/display_scheduler_bin_to_bcd_seq.sv
// Sequential double-dabble: one shift per cycle, 14 shifts in total, with the
// first shift taken on the start edge. done pulses once when bcd is final.
module bin_to_bcd_seq
    import display_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int unsigned CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             running;

    // Add-3 correction on every nibble >= 5, then shift in the next binary bit.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] acc,
                                                 input logic             bit_in);
        logic [BCD_W-1:0] adj;
        adj = acc;
        for (int d = 0; d < int'(NUM_DIG); d++) begin
            if (adj[d*DIG_W +: DIG_W] >= 4'd5) begin
                adj[d*DIG_W +: DIG_W] = adj[d*DIG_W +: DIG_W] + 4'd3;
            end
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd     <= dd_step('0, bin[VAL_W-1]);
                sr      <= {bin[VAL_W-2:0], 1'b0};
                cnt     <= CNT_W'(VAL_W - 1);
                running <= 1'b1;
            end else if (running) begin
                bcd <= dd_step(bcd, sr[VAL_W-1]);
                sr  <= {sr[VAL_W-2:0], 1'b0};
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin arbiter that captures one of four 14-bit values, converts it to
// blanked BCD, holds it on a 4-digit multiplexed display for HOLD_CYCLES.
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter int unsigned SCAN_BITS   = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*VAL_W-1:0] value_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [ID_W-1:0]          src_id,
    output logic [EN_W-1:0]          en_out,
    output logic [DIG_W-1:0]         in4
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    state_t            state;
    logic [ID_W-1:0]   last_id;
    logic [VAL_W-1:0]  value_q;
    logic              oor_q;
    logic              conv_start;
    logic              conv_done;
    logic [BCD_W-1:0]  conv_bcd;
    logic [BCD_W-1:0]  digits;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SCAN_BITS-1:0] scan_cnt;
    logic [2:0]        scan_sel;
    logic [ID_W-1:0]   pick;
    logic [VAL_W-1:0]  pick_val;

    assign pick     = rr_pick(req, last_id);
    assign pick_val = value_in[32'(pick)*VAL_W +: VAL_W];
    assign scan_sel = scan_cnt[SCAN_BITS-1 -: 3];

    bin_to_bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (value_q),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Scheduler FSM; digits only move on the CONVERT->HOLD edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            busy       <= 1'b0;
            src_id     <= '0;
            last_id    <= ID_W'(NUM_REQ - 1);
            value_q    <= '0;
            oor_q      <= 1'b0;
            conv_start <= 1'b0;
            digits     <= {NUM_DIG{BLANK_CODE}};
            hold_cnt   <= '0;
        end else begin
            grant      <= '0;
            conv_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req != '0) begin
                        grant      <= NUM_REQ'(1) << pick;
                        src_id     <= pick;
                        last_id    <= pick;
                        value_q    <= pick_val;
                        oor_q      <= (pick_val > MAX_DISPLAY);
                        conv_start <= (pick_val <= MAX_DISPLAY);
                        busy       <= 1'b1;
                        state      <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (oor_q) begin
                        digits   <= {NUM_DIG{BLANK_CODE}};
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                    end else if (conv_done) begin
                        digits   <= blank_leading(conv_bcd);
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running scan; top three counter bits pick digit 0..3 or a dark slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            en_out   <= 8'hFF;
            in4      <= BLANK_CODE;
        end else begin
            scan_cnt <= scan_cnt + SCAN_BITS'(1);
            if (!scan_sel[2]) begin
                en_out <= ~(EN_W'(1) << scan_sel[1:0]);
                in4    <= digits[32'(scan_sel[1:0])*DIG_W +: DIG_W];
            end else begin
                en_out <= 8'hFF;
                in4    <= BLANK_CODE;
            end
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler with HOLD_CYCLES=20, SCAN_BITS=6.
module tb_display_scheduler;
    import display_scheduler_pkg::*;

    localparam int unsigned HOLD  = 20;
    localparam int unsigned SBITS = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req;
    logic [55:0] value_in;
    logic [3:0]  grant;
    logic        busy;
    logic [1:0]  src_id;
    logic [7:0]  en_out;
    logic [3:0]  in4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  grant;
        logic [1:0]  src;
        logic [15:0] digits;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] rr_last;

    display_scheduler #(.HOLD_CYCLES(HOLD), .SCAN_BITS(SBITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .value_in (value_in),
        .grant    (grant),
        .busy     (busy),
        .src_id   (src_id),
        .en_out   (en_out),
        .in4      (in4)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_digits(input int v);
        logic [15:0] d;
        if (v > 9999) return 16'hFFFF;
        d[3:0]   = 4'(v % 10);
        d[7:4]   = (v < 10)   ? 4'hF : 4'((v / 10) % 10);
        d[11:8]  = (v < 100)  ? 4'hF : 4'((v / 100) % 10);
        d[15:12] = (v < 1000) ? 4'hF : 4'(v / 1000);
        return d;
    endfunction

    function automatic int model_pick(input logic [3:0] r, input logic [1:0] last);
        int idx;
        for (int i = 1; i <= 4; i++) begin
            idx = (int'(last) + i) % 4;
            if (r[idx]) return idx;
        end
        return int'(last);
    endfunction

    task automatic push_exp(input logic [3:0] r, input logic [55:0] vals);
        exp_t e;
        int   k;
        k         = model_pick(r, rr_last);
        rr_last   = 2'(k);
        e.grant   = 4'(1 << k);
        e.src     = 2'(k);
        e.digits  = model_digits(int'(vals[k*14 +: 14]));
        sb.push_back(e);
    endtask

    task automatic wait_grant(input int limit, output int lat, output bit ok, output exp_t e);
        ok  = 1'b0;
        lat = 0;
        e   = '{grant: 4'h0, src: 2'd0, digits: 16'h0};
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (grant != 4'b0) begin
                ok = 1'b1;
                break;
            end
            lat++;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL grant_timeout: no grant within %0d cycles", limit);
            return;
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant: grant=%b with empty scoreboard", grant);
            ok = 1'b0;
            return;
        end
        e = sb.pop_front();
        checks++;
        if (grant !== e.grant) begin
            errors++;
            $display("FAIL grant_onehot: got %b want %b", grant, e.grant);
        end
        checks++;
        if (src_id !== e.src) begin
            errors++;
            $display("FAIL src_id: got %0d want %0d", src_id, e.src);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", name, busy, n);
        end
    endtask

    task automatic read_display(input string name, input logic [15:0] want);
        logic [15:0] d;
        logic [3:0]  seen;
        d    = 16'h0;
        seen = 4'h0;
        for (int n = 0; n < 200 && seen != 4'hF; n++) begin
            @(negedge clk);
            case (en_out)
                8'b11111110: begin d[3:0]   = in4; seen[0] = 1'b1; end
                8'b11111101: begin d[7:4]   = in4; seen[1] = 1'b1; end
                8'b11111011: begin d[11:8]  = in4; seen[2] = 1'b1; end
                8'b11110111: begin d[15:12] = in4; seen[3] = 1'b1; end
                default: ;
            endcase
        end
        checks++;
        if (seen != 4'hF || d !== want) begin
            errors++;
            $display("FAIL %s_digits: got %h (seen %b) want %h", name, d, seen, want);
        end
    endtask

    task automatic run_single(input string name, input logic [3:0] r, input int k,
                              input int v, input int busy_exp);
        exp_t e;
        int   lat;
        int   blen;
        bit   ok;
        value_in = '0;
        value_in[k*14 +: 14] = 14'(v);
        push_exp(r, value_in);
        req = r;
        wait_grant(64, lat, ok, e);
        req = 4'b0;
        if (!ok) return;
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL %s_latency: got %0d want 0", name, lat);
        end
        blen = 0;
        while (busy === 1'b1 && blen < 200) begin
            blen++;
            @(negedge clk);
            if (blen == 1) begin
                checks++;
                if (grant !== 4'b0) begin
                    errors++;
                    $display("FAIL %s_grant_width: got %b want 0000", name, grant);
                end
            end
        end
        checks++;
        if (blen != busy_exp) begin
            errors++;
            $display("FAIL %s_busy_len: got %0d want %0d", name, blen, busy_exp);
        end
        read_display(name, e.digits);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (en_out !== 8'hFF || in4 !== 4'hF || busy !== 1'b0 || grant !== 4'b0 || src_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: en_out=%h in4=%h busy=%b grant=%b src=%0d want ff f 0 0000 0",
                     en_out, in4, busy, grant, src_id);
        end
        rst_n = 1'b1;
        @(negedge clk);
        read_display("reset_blank", 16'hFFFF);
    endtask

    task automatic test_single();
        run_single("single", 4'b0010, 1, 1234, 35);
    endtask

    task automatic test_boundaries();
        run_single("b9999",  4'b0001, 0, 9999,  35);
        run_single("b10000", 4'b0010, 1, 10000, 21);
        run_single("b0",     4'b0100, 2, 0,     35);
        run_single("b7",     4'b1000, 3, 7,     35);
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   lat;
        bit   ok;
        value_in = {14'd4, 14'd3, 14'd2, 14'd1};
        for (int i = 0; i < 5; i++) push_exp(4'b1111, value_in);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(80, lat, ok, e);
            if (!ok) break;
            checks++;
            if ((i == 0 && lat != 0) || (i > 0 && lat + 1 != 36)) begin
                errors++;
                $display("FAIL rr_spacing[%0d]: got %0d want %0d", i, (i == 0) ? lat : lat + 1,
                         (i == 0) ? 0 : 36);
            end
        end
        req = 4'b0;
        sb.delete();
        wait_idle("rr");
    endtask

    task automatic test_hold_isolation();
        exp_t e;
        int   lat;
        int   n;
        bit   ok;
        value_in = '0;
        value_in[2*14 +: 14] = 14'd55;
        value_in[0 +: 14]    = 14'd4321;
        push_exp(4'b0100, value_in);
        req = 4'b0100;
        wait_grant(64, lat, ok, e);
        req = 4'b0;
        if (!ok) return;
        repeat (15) @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n == 5) begin
                push_exp(4'b0001, value_in);
                req = 4'b0001;
            end
            checks++;
            if (grant !== 4'b0) begin
                errors++;
                $display("FAIL hold_grant[%0d]: got %b want 0000", n, grant);
            end
            if (en_out == 8'b11111110 || en_out == 8'b11111101) begin
                checks++;
                if (in4 !== 4'd5) begin
                    errors++;
                    $display("FAIL hold_digit en=%b: got %h want 5", en_out, in4);
                end
            end else if (en_out == 8'b11111011 || en_out == 8'b11110111) begin
                checks++;
                if (in4 !== 4'hF) begin
                    errors++;
                    $display("FAIL hold_digit en=%b: got %h want f", en_out, in4);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (grant !== 4'b0) begin
            errors++;
            $display("FAIL hold_idle_cycle: got %b want 0000", grant);
        end
        wait_grant(8, lat, ok, e);
        req = 4'b0;
        if (!ok) return;
        checks++;
        if (lat != 0) begin
            errors++;
            $display("FAIL hold_regrant_latency: got %0d want 0", lat);
        end
        wait_idle("hold");
        read_display("hold_final", e.digits);
    endtask

    task automatic test_scan();
        logic [15:0] d;
        logic [7:0]  exp_en;
        logic [3:0]  exp_in4;
        bit          aligned;
        int          n;
        d       = model_digits(4321);
        aligned = 1'b0;
        n       = 0;
        while (en_out !== 8'hFF && n < 200) begin @(negedge clk); n++; end
        while (en_out === 8'hFF && n < 200) begin @(negedge clk); n++; end
        aligned = (en_out === 8'b11111110);
        checks++;
        if (!aligned) begin
            errors++;
            $display("FAIL scan_align: got en_out=%b want 11111110 after dark slot", en_out);
            return;
        end
        for (int i = 0; i < 64; i++) begin
            if (i < 32) begin
                exp_en  = ~(8'(1) << (i / 8));
                exp_in4 = d[(i / 8) * 4 +: 4];
            end else begin
                exp_en  = 8'hFF;
                exp_in4 = 4'hF;
            end
            checks++;
            if (en_out !== exp_en || in4 !== exp_in4) begin
                errors++;
                $display("FAIL scan[%0d]: got en=%b in4=%h want en=%b in4=%h",
                         i, en_out, in4, exp_en, exp_in4);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_hold();
        exp_t e;
        int   lat;
        bit   ok;
        value_in = '0;
        value_in[3*14 +: 14] = 14'd500;
        push_exp(4'b1000, value_in);
        req = 4'b1000;
        wait_grant(64, lat, ok, e);
        req = 4'b0;
        if (!ok) return;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (en_out !== 8'hFF || in4 !== 4'hF || busy !== 1'b0 || grant !== 4'b0 || src_id !== 2'd0) begin
            errors++;
            $display("FAIL midhold_reset: en_out=%h in4=%h busy=%b grant=%b src=%0d want ff f 0 0000 0",
                     en_out, in4, busy, grant, src_id);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        rr_last = 2'd3;
        read_display("post_reset_blank", 16'hFFFF);
        run_single("post_reset_rr", 4'b0011, 0, 42, 35);
    endtask

    initial begin
        req      = 4'b0;
        value_in = '0;
        rr_last  = 2'd3;
        test_reset();
        test_single();
        test_boundaries();
        test_round_robin();
        test_hold_isolation();
        test_scan();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
